// File: rtl/alu_writeback_stage.sv
// Writeback stage: commits an ALU result to A/D, updates the PC and performs single-beat
// memory writes. Define ALU_WB_FLAGS_EN to register zero/negative flags on each accept.
module alu_writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alu_out,
  input  logic        dst_a,
  input  logic        dst_d,
  input  logic        dst_m,
  input  logic        lt,
  input  logic        eq,
  input  logic        gt,
  output logic [15:0] reg_a,
  output logic [15:0] reg_d,
  output logic [15:0] pc,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        zf,
  output logic        nf
);

  typedef enum logic [0:0] {StIdle, StMemWait} state_e;

  state_e      state_q;
  logic [15:0] reg_a_q, reg_d_q, pc_q, mem_addr_q, mem_wdata_q;
  logic        mem_we_q, jump_q;

  logic        accept;
  logic        jump;
  logic [15:0] pc_inc;

  assign accept = (state_q == StIdle) & in_valid;
  assign jump   = (lt & alu_out[15]) | (eq & (alu_out == 16'h0000)) |
                  (gt & ~alu_out[15] & (alu_out != 16'h0000));
  assign pc_inc = pc_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      reg_a_q     <= 16'h0000;
      reg_d_q     <= 16'h0000;
      pc_q        <= 16'h0000;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      jump_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (dst_a) reg_a_q <= alu_out;
            if (dst_d) reg_d_q <= alu_out;
            if (dst_m) begin
              // Target is the pre-accept A; mem_addr_q keeps it for the ack edge.
              mem_addr_q  <= reg_a_q;
              mem_wdata_q <= alu_out;
              jump_q      <= jump;
              mem_we_q    <= 1'b1;
              state_q     <= StMemWait;
            end else begin
              pc_q <= jump ? reg_a_q : pc_inc;
            end
          end
        end
        StMemWait: begin
          if (mem_ack) begin
            pc_q     <= jump_q ? mem_addr_q : pc_inc;
            mem_we_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_WB_FLAGS_EN
  logic zf_q, nf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      nf_q <= 1'b0;
    end else if (accept) begin
      zf_q <= (alu_out == 16'h0000);
      nf_q <= alu_out[15];
    end
  end

  assign zf = zf_q;
  assign nf = nf_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign zf = 1'b0;
  assign nf = 1'b0;
`endif

  assign in_ready  = (state_q == StIdle) & ~rst;
  assign reg_a     = reg_a_q;
  assign reg_d     = reg_d_q;
  assign pc        = pc_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
